// File: rtl/aes_pkg.sv
// Shared AES constants: round count, forward S-box table, round-constant table.
// The forward rcon generator and the reverse key schedule both read rcon_byte()
// so the two directions cannot disagree.
package aes_pkg;

    localparam int AES_NR = 10;

    // Forward S-box, entry 0 in the top byte, entry 255 in the bottom byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } krev_state_e;

    // Round constant used when stepping into/out of round r; unused codes give 0.
    function automatic logic [7:0] rcon_byte(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Byte lookup into SBOX_TBL (entry a sits at bit offset 2040 - 8*a).
    function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
        logic [10:0] base;
        base = 11'd2040 - {a, 3'b000};
        return SBOX_TBL[base +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    // Table lookup of the substituted byte.
    always_comb begin
        s = sbox_lookup(a);
    end

endmodule

// File: rtl/aes_key_rev.sv
// Reverse AES-128 key schedule: loaded with the round-10 key, it steps back one
// round per accepted key and presents round keys 10 down to 0.
module aes_key_rev
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key_in,
    input  logic         rk_rdy,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_vld,
    output logic         done
);

    localparam logic [3:0] NR_IDX = 4'(NR);

    krev_state_e  state_r;
    logic [127:0] key_r;
    logic [3:0]   idx_r;
    logic         done_r;

    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic [31:0]  p0_s, p1_s, p2_s, p3_s;
    logic [31:0]  rot_s;
    logic [31:0]  sub_s;
    logic [127:0] prev_s;

    // Split the held key into words and form the three pure-XOR words of the previous key.
    always_comb begin
        w0_s  = key_r[127:96];
        w1_s  = key_r[95:64];
        w2_s  = key_r[63:32];
        w3_s  = key_r[31:0];
        p3_s  = w3_s ^ w2_s;
        p2_s  = w2_s ^ w1_s;
        p1_s  = w1_s ^ w0_s;
        rot_s = {p3_s[23:0], p3_s[31:24]};
    end

    // SubWord of the rotated p3, one S-box per byte lane.
    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot_s[8*g +: 8]),
            .s (sub_s[8*g +: 8])
        );
    end

    // Recover w0 of the previous round key using the rcon of the current round.
    always_comb begin
        p0_s   = w0_s ^ sub_s ^ {rcon_byte(idx_r), 24'h000000};
        prev_s = {p0_s, p1_s, p2_s, p3_s};
    end

    // Walk FSM: load, step back on each accepted key, finish with a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            key_r   <= 128'h0;
            idx_r   <= 4'd0;
            done_r  <= 1'b0;
        end else if (kld) begin
            state_r <= ST_WALK;
            key_r   <= key_in;
            idx_r   <= NR_IDX;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_WALK: begin
                    if (rk_rdy) begin
                        if (idx_r != 4'd0) begin
                            key_r  <= prev_s;
                            idx_r  <= idx_r - 4'd1;
                            done_r <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rk_out = key_r;
    assign rk_idx = idx_r;
    assign rk_vld = (state_r == ST_WALK);
    assign done   = done_r;

endmodule

// File: tb/tb_aes_key_rev.sv
// Bench for aes_key_rev: a forward key expansion (S-box built from GF(2^8)
// inversion) yields the expected reverse sequence; a cycle model checks every cycle.
module tb_aes_key_rev;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         kld = 1'b0;
    logic         rk_rdy = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_vld;
    logic         done;

    always #5 clk = ~clk;

    aes_key_rev dut (
        .clk    (clk),
        .rst    (rst),
        .kld    (kld),
        .key_in (key_in),
        .rk_rdy (rk_rdy),
        .rk_out (rk_out),
        .rk_idx (rk_idx),
        .rk_vld (rk_vld),
        .done   (done)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    int           done_cnt = 0;
    bit           chk_en = 1'b0;
    logic [7:0]   sb [0:255];
    logic [127:0] pend_tbl [0:10];
    logic [127:0] cur_tbl [0:10];
    logic [127:0] seen_key [0:15];
    logic         m_vld = 1'b0;
    logic         m_done = 1'b0;
    logic [3:0]   m_idx = 4'd0;
    logic [127:0] m_key = 128'h0;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Forward AES-128 expansion of cipher key k into pend_tbl[0..10].
    task automatic load_schedule(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            pend_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Cycle model: what the outputs must be after each clock edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_vld  <= 1'b0;
            m_done <= 1'b0;
            m_idx  <= 4'd0;
            m_key  <= 128'h0;
        end else if (kld) begin
            cur_tbl <= pend_tbl;
            m_key   <= key_in;
            m_idx   <= 4'd10;
            m_vld   <= 1'b1;
            m_done  <= 1'b0;
        end else if (m_vld && rk_rdy) begin
            if (m_idx != 4'd0) begin
                m_key  <= cur_tbl[m_idx - 4'd1];
                m_idx  <= m_idx - 4'd1;
                m_done <= 1'b0;
            end else begin
                m_vld  <= 1'b0;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp = n_cmp + 1;
            if ({rk_vld, done, rk_idx, rk_out} !== {m_vld, m_done, m_idx, m_key}) begin
                n_err = n_err + 1;
                $display("FAIL cycle_cmp t=%0t: got vld=%b done=%b idx=%0d key=%h, expected vld=%b done=%b idx=%0d key=%h",
                         $time, rk_vld, done, rk_idx, rk_out, m_vld, m_done, m_idx, m_key);
            end
            if (done) done_cnt = done_cnt + 1;
            if (rk_vld) seen_key[rk_idx] = rk_out;
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [127:0] k);
        load_schedule(k);
        key_in = pend_tbl[10];
        kld    = 1'b1;
        @(negedge clk);
        kld    = 1'b0;
    endtask

    task automatic run_walk(input bit rnd, output int n);
        n = 0;
        while (!done && n < 400) begin
            rk_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            n++;
        end
        if (!done) check("walk_timeout", 128'(n), 128'd0);
    endtask

    task automatic wait_idx(input logic [3:0] target);
        int n = 0;
        while (!(rk_vld && rk_idx == target) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("wait_idx_timeout", 128'(rk_idx), 128'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        logic [127:0] ka, kb;

        build_sbox();
        check("sbox_00", 128'(sb[8'h00]), 128'h63);
        check("sbox_53", 128'(sb[8'h53]), 128'hed);
        load_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("fwd_rk10", pend_tbl[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fwd_rk9",  pend_tbl[9],  128'hac7766f319fadc2128d12941575c006e);
        check("fwd_rk1",  pend_tbl[1],  128'ha0fafe1788542cb123a339392a6c7605);

        // Reset state
        rst = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out", rk_out, 128'h0);
        check("rst_flags", {rk_vld, done, rk_idx}, 128'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: back-to-back walk of the FIPS-197 key
        rk_rdy = 1'b1;
        start(128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("t1_idx10", 128'(rk_idx), 128'd10);
        check("t1_key10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_walk(1'b0, n);
        check("t1_done_latency", 128'(n), 128'd11);
        check("t1_key9", seen_key[9], 128'hac7766f319fadc2128d12941575c006e);
        check("t1_key1", seen_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("t1_key0", seen_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Test 6: rk_rdy held after done
        @(negedge clk);
        snap = done_cnt;
        repeat (5) @(negedge clk);
        check("t6_vld", 128'(rk_vld), 128'd0);
        check("t6_key_hold", rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("t6_no_done", 128'(done_cnt), 128'(snap));

        // Test 2: random back-pressure
        done_cnt = 0;
        start(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_walk(1'b1, n);
        rk_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("t2_done_once", 128'(done_cnt), 128'd1);
        check("t2_key1", seen_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("t2_key0", seen_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Test 3: reload mid-walk
        done_cnt = 0;
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        rk_rdy = 1'b1;
        start(ka);
        wait_idx(4'd5);
        start(kb);
        check("t3_idx10", 128'(rk_idx), 128'd10);
        check("t3_key10", rk_out, pend_tbl[10]);
        check("t3_no_done", 128'(done_cnt), 128'd0);
        run_walk(1'b0, n);
        check("t3_key0", seen_key[0], kb);

        // Test 4: reset beats kld mid-walk
        repeat (2) @(negedge clk);
        start(ka);
        wait_idx(4'd7);
        rst = 1'b0;
        kld = 1'b1;
        key_in = 128'hffffffffffffffffffffffffffffffff;
        @(negedge clk);
        check("t4_out", rk_out, 128'h0);
        check("t4_flags", {rk_vld, done, rk_idx}, 128'h0);
        rst = 1'b1;
        kld = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_idle", {rk_vld, rk_idx}, 128'h0);

        // Test 5: ten random keys against the forward schedule
        for (int k = 0; k < 10; k++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            start(ka);
            run_walk(1'b1, n);
            check("t5_key0", seen_key[0], ka);
            rk_rdy = 1'b0;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
